// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// parameter range helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_adder_unit.sv
// One-bit combinational full adder; the only arithmetic element of the
// serial adder, reused once per bit position over successive cycles.
module full_adder_unit (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = Ain ^ Bin ^ Cin;
  assign Cout = (Ain & Bin) | (Ain & Cin) | (Bin & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: latches a/b/cin on start, adds one bit per clock LSB
// first through a carry flop, and publishes {cout,sum} with a done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range 1..32");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   sh_s_q, sh_s_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   sh_s_next;

  full_adder_unit u_fa (
    .Ain  (sh_a_q[0]),
    .Bin  (sh_b_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  assign sh_s_next = (sh_s_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        sh_s_d  = sh_s_next;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sh_s_next;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that sequences one full_adder_unit across a WIDTH-bit operand pair, LSB first, one bit per clock. It latches operands on a start/busy/done handshake, runs a carry-save loop through a carry flip-flop, and presents a registered WIDTH-bit sum plus carry-out. This is the area-minimal alternative to a ripple-carry adder in the Adder family.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 1..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request: sample a, b, cin this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to bit 0
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse; sum/cout valid from this cycle
sum  output  WIDTH  registered result, held until next completion
cout  output  1  registered carry-out of MSB, held with sum

Behaviour:
- Interface (already decided): single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry FF and counter=0. Reset applies immediately and overrides any in-flight operation, with no partial result committed.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - Start=1 at an edge loads shA<=a, shB<=b, carry<=cin, cnt<=0, and moves the FSM to RUN.
  - Start=0 keeps the FSM in IDLE.
- RUN (busy=1):
  - Each edge feeds full_adder_unit with Ain=shA[0], Bin=shB[0], Cin=carry.
  - On that edge: shA/shB shift right by 1, S shifts into shS MSB (shS>>1), carry<=Cout, cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: sum<=final shS (including this bit), cout<=Cout, done<=1, next state DONE.
- DONE (busy=0, done=1 for exactly this cycle):
  - Start=1 behaves as in IDLE and gives a back-to-back load into RUN.
  - Otherwise the FSM goes to IDLE.
  - done deasserts after one cycle in both cases.
- Latency: start sampled at edge k gives done high during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not re-sampled, and a/b may change freely during RUN.
- sum/cout change only at completion. They are stable during RUN and show the previous result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- WIDTH=1: a single RUN cycle; same rules apply.
- No X propagation: all registers are reset. Unknown start in IDLE is a bench error.

Decomposition:
- Package serial_add_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - a width-check helper for WIDTH range.
- Single sub-module: the existing one-bit full_adder_unit (ports Ain, Bin, Cin, S, Cout), instantiated once, purely combinational.
- The FSM, counter, shift registers and carry FF live in serial_add_ctrl. No further hierarchy.

Test Plan:
1. WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start pulse -> busy high 8 cycles; done pulse 9th cycle; sum=8'h96, cout=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
3. Start a=8'h10, b=8'h20, then start=1 with a=8'hAA, b=8'h55 at RUN cycle 3 -> ignored; result sum=8'h30, cout=0, with only one done pulse.
4. rst_n low at RUN cycle 4 of a=8'h80+b=8'h80 -> immediately busy=0, done=0, sum=0, cout=0. After release, a=8'h01+b=8'h02 -> sum=8'h03.
5. Back-to-back: start held high in DONE cycle with a=8'h7F, b=8'h01, cin=0 -> new RUN with no IDLE cycle; sum=8'h80, cout=0, done 9 cycles later.
6. WIDTH=1 instance, all 8 (a,b,cin) combos -> {cout,sum} equals a+b+cin, with done 2 cycles after each start.
